// File: rtl/random_engine_seq_ctrl.sv
// Sequencing controller for the LFSR random engine: seed load, warm-up discard,
// valid/ready word handshake and continuous or fixed-length burst runs.
module random_engine_seq_ctrl #(
  parameter int CNT_W  = 16,
  parameter int WARMUP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             seed_load,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             lfsr_load,
  output logic             lfsr_en,
  output logic             active,
  output logic             done,
  output logic [CNT_W-1:0] count_out
);

  localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WARM_W-1:0] WARM_LAST = (WARMUP > 0) ? WARM_W'(WARMUP - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WARM,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              mode_q;
  logic [CNT_W-1:0]  len_q;
  logic [WARM_W-1:0] warm_cnt;

  logic accept;
  logic transfer;
  logic burst_last;
  logic empty_burst;

  assign accept      = (state == S_IDLE) && start && !stop;
  assign empty_burst = mode_q && (len_q == '0);
  assign burst_last  = mode_q && (count_out == (len_q - CNT_W'(1)));

  // Datapath strobes stay combinational on stop/out_ready so a stop or a
  // stalled consumer takes effect in the very cycle it is seen.
  assign out_valid = (state == S_RUN) && !stop;
  assign transfer  = out_valid && out_ready;
  assign lfsr_load = (state == S_LOAD) && !stop;
  assign lfsr_en   = ((state == S_WARM) && !stop) || transfer;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (seed_load)
            state_nxt = S_LOAD;
          else if (mode && (burst_len == '0))
            state_nxt = S_DONE;
          else
            state_nxt = S_RUN;
        end
      end
      S_LOAD: begin
        if (stop)
          state_nxt = S_IDLE;
        else if (WARMUP > 0)
          state_nxt = S_WARM;
        else if (empty_burst)
          state_nxt = S_DONE;
        else
          state_nxt = S_RUN;
      end
      S_WARM: begin
        if (stop)
          state_nxt = S_IDLE;
        else if (warm_cnt == WARM_LAST)
          state_nxt = empty_burst ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (stop)
          state_nxt = S_IDLE;
        else if (transfer && burst_last)
          state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // active/done are registered from the next state so they are glitch-free
  // decodes of the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      active    <= 1'b0;
      done      <= 1'b0;
      mode_q    <= 1'b0;
      len_q     <= '0;
      warm_cnt  <= '0;
      count_out <= '0;
    end else begin
      state  <= state_nxt;
      active <= (state_nxt == S_LOAD) || (state_nxt == S_WARM) || (state_nxt == S_RUN);
      done   <= (state_nxt == S_DONE);
      if (accept) begin
        mode_q <= mode;
        len_q  <= burst_len;
      end
      warm_cnt <= (state == S_WARM) ? warm_cnt + WARM_W'(1) : '0;
      if (accept)
        count_out <= '0;
      else if (transfer)
        count_out <= count_out + CNT_W'(1);
    end
  end

  a_load_en_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(lfsr_load && lfsr_en));

  a_valid_held: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid || stop));

endmodule

// File: tb/tb_random_engine_seq_ctrl.sv
// Directed bench for random_engine_seq_ctrl: a default instance (CNT_W=16, WARMUP=8)
// and a narrow instance (CNT_W=4, WARMUP=0) for wrap and no-warm-up seeding.
module tb_random_engine_seq_ctrl;

  logic clk;
  logic rst_n;

  logic        a_start, a_stop, a_mode, a_seed, a_ready;
  logic [15:0] a_len;
  logic        a_valid, a_load, a_en, a_active, a_done;
  logic [15:0] a_count;
  logic [4:0]  a_vec;

  logic        b_start, b_stop, b_mode, b_seed, b_ready;
  logic [3:0]  b_len;
  logic        b_valid, b_load, b_en, b_active, b_done;
  logic [3:0]  b_count;
  logic [4:0]  b_vec;

  int total;
  int bad;

  assign a_vec = {a_valid, a_load, a_en, a_active, a_done};
  assign b_vec = {b_valid, b_load, b_en, b_active, b_done};

  random_engine_seq_ctrl #(.CNT_W(16), .WARMUP(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .stop(a_stop), .mode(a_mode),
    .seed_load(a_seed), .burst_len(a_len), .out_ready(a_ready), .out_valid(a_valid),
    .lfsr_load(a_load), .lfsr_en(a_en), .active(a_active), .done(a_done),
    .count_out(a_count)
  );

  random_engine_seq_ctrl #(.CNT_W(4), .WARMUP(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .stop(b_stop), .mode(b_mode),
    .seed_load(b_seed), .burst_len(b_len), .out_ready(b_ready), .out_valid(b_valid),
    .lfsr_load(b_load), .lfsr_en(b_en), .active(b_active), .done(b_done),
    .count_out(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (a_vec !== 5'b00000 || a_count !== 16'd0) begin
      bad++;
      $display("[TB] FAIL reset_init vec=%b count=%0d exp vec=00000 count=0", a_vec, a_count);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    a_start = 1'b1; a_mode = 1'b0; a_seed = 1'b0; a_ready = 1'b1;
    cyc();
    a_start = 1'b0;
    #1;
    total++;
    if (a_vec !== 5'b10110 || a_count !== 16'd0) begin
      bad++;
      $display("[TB] FAIL reset_run_entry vec=%b count=%0d exp vec=10110 count=0", a_vec, a_count);
    end
    cyc();
    cyc();
    total++;
    if (a_count !== 16'd2) begin
      bad++;
      $display("[TB] FAIL reset_pre_count got=%0d exp=2", a_count);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (a_vec !== 5'b00000 || a_count !== 16'd0) begin
      bad++;
      $display("[TB] FAIL reset_midrun vec=%b count=%0d exp vec=00000 count=0", a_vec, a_count);
    end
    cyc();
    rst_n = 1'b1;
    a_ready = 1'b0;
    cyc();
    total++;
    if (a_vec !== 5'b00000 || a_count !== 16'd0) begin
      bad++;
      $display("[TB] FAIL reset_release vec=%b count=%0d exp vec=00000 count=0", a_vec, a_count);
    end
  endtask

  task automatic test_seeded_burst();
    a_start = 1'b1; a_mode = 1'b1; a_seed = 1'b1; a_len = 16'd4; a_ready = 1'b1;
    cyc();
    a_start = 1'b0;
    #1;
    total++;
    if (a_vec !== 5'b01010) begin
      bad++;
      $display("[TB] FAIL burst_load vec=%b exp=01010", a_vec);
    end
    cyc();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (a_vec !== 5'b00110) begin
        bad++;
        $display("[TB] FAIL burst_warm%0d vec=%b exp=00110", i, a_vec);
      end
      cyc();
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (a_vec !== 5'b10110 || a_count !== 16'(i)) begin
        bad++;
        $display("[TB] FAIL burst_xfer%0d vec=%b count=%0d exp vec=10110 count=%0d", i, a_vec, a_count, i);
      end
      cyc();
    end
    total++;
    if (a_vec !== 5'b00001 || a_count !== 16'd4) begin
      bad++;
      $display("[TB] FAIL burst_done vec=%b count=%0d exp vec=00001 count=4", a_vec, a_count);
    end
    cyc();
    total++;
    if (a_vec !== 5'b00000 || a_count !== 16'd4) begin
      bad++;
      $display("[TB] FAIL burst_idle vec=%b count=%0d exp vec=00000 count=4", a_vec, a_count);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] ready_pat;
    ready_pat = 4'b1001;
    a_start = 1'b1; a_mode = 1'b0; a_seed = 1'b0;
    cyc();
    a_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_ready = ready_pat[3-i];
      #1;
      total++;
      if (a_valid !== 1'b1 || a_en !== ready_pat[3-i]) begin
        bad++;
        $display("[TB] FAIL bp_cycle%0d valid=%b en=%b exp valid=1 en=%b", i, a_valid, a_en, ready_pat[3-i]);
      end
      cyc();
    end
    total++;
    if (a_count !== 16'd2) begin
      bad++;
      $display("[TB] FAIL bp_count got=%0d exp=2", a_count);
    end
    a_stop = 1'b1;
    #1;
    total++;
    if (a_vec !== 5'b00010) begin
      bad++;
      $display("[TB] FAIL bp_stop vec=%b exp=00010", a_vec);
    end
    cyc();
    a_stop = 1'b0;
    total++;
    if (a_vec !== 5'b00000 || a_count !== 16'd2) begin
      bad++;
      $display("[TB] FAIL bp_after_stop vec=%b count=%0d exp vec=00000 count=2", a_vec, a_count);
    end
  endtask

  task automatic test_stop_priority();
    a_start = 1'b1; a_mode = 1'b1; a_seed = 1'b0; a_len = 16'd3; a_ready = 1'b1;
    cyc();
    a_start = 1'b0;
    cyc();
    cyc();
    a_stop = 1'b1;
    #1;
    total++;
    if (a_vec !== 5'b00010 || a_count !== 16'd2) begin
      bad++;
      $display("[TB] FAIL stop_cycle vec=%b count=%0d exp vec=00010 count=2", a_vec, a_count);
    end
    cyc();
    a_stop = 1'b0;
    total++;
    if (a_vec !== 5'b00000 || a_count !== 16'd2) begin
      bad++;
      $display("[TB] FAIL stop_idle vec=%b count=%0d exp vec=00000 count=2", a_vec, a_count);
    end
  endtask

  task automatic test_corner_starts();
    a_start = 1'b1; a_mode = 1'b1; a_seed = 1'b0; a_len = 16'd0; a_ready = 1'b0;
    cyc();
    a_start = 1'b0;
    total++;
    if (a_vec !== 5'b00001 || a_count !== 16'd0) begin
      bad++;
      $display("[TB] FAIL zero_len_done vec=%b count=%0d exp vec=00001 count=0", a_vec, a_count);
    end
    cyc();
    total++;
    if (a_vec !== 5'b00000) begin
      bad++;
      $display("[TB] FAIL zero_len_idle vec=%b exp=00000", a_vec);
    end
    a_start = 1'b1; a_stop = 1'b1; a_mode = 1'b0;
    cyc();
    a_start = 1'b0; a_stop = 1'b0;
    total++;
    if (a_vec !== 5'b00000) begin
      bad++;
      $display("[TB] FAIL start_stop_idle vec=%b exp=00000", a_vec);
    end
    a_start = 1'b1; a_mode = 1'b1; a_len = 16'd2; a_ready = 1'b0;
    cyc();
    a_mode = 1'b0; a_len = 16'd10;
    #1;
    total++;
    if (a_vec !== 5'b10010) begin
      bad++;
      $display("[TB] FAIL relatch_stall vec=%b exp=10010", a_vec);
    end
    cyc();
    a_start = 1'b0;
    a_ready = 1'b1;
    #1;
    total++;
    if (a_vec !== 5'b10110 || a_count !== 16'd0) begin
      bad++;
      $display("[TB] FAIL relatch_xfer0 vec=%b count=%0d exp vec=10110 count=0", a_vec, a_count);
    end
    cyc();
    cyc();
    total++;
    if (a_vec !== 5'b00001 || a_count !== 16'd2) begin
      bad++;
      $display("[TB] FAIL relatch_done vec=%b count=%0d exp vec=00001 count=2", a_vec, a_count);
    end
    a_ready = 1'b0;
    cyc();
  endtask

  task automatic test_wrap();
    int done_seen;
    done_seen = 0;
    b_start = 1'b1; b_mode = 1'b0; b_seed = 1'b0; b_ready = 1'b1;
    cyc();
    b_start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (b_done) done_seen++;
      cyc();
    end
    total++;
    if (b_count !== 4'd1 || b_active !== 1'b1 || b_valid !== 1'b1 || done_seen !== 0) begin
      bad++;
      $display("[TB] FAIL wrap_count count=%0d active=%b valid=%b dones=%0d exp count=1 active=1 valid=1 dones=0",
               b_count, b_active, b_valid, done_seen);
    end
    b_stop = 1'b1;
    cyc();
    b_stop = 1'b0;
    b_start = 1'b1; b_mode = 1'b1; b_seed = 1'b1; b_len = 4'd1;
    cyc();
    b_start = 1'b0;
    total++;
    if (b_vec !== 5'b01010 || b_count !== 4'd0) begin
      bad++;
      $display("[TB] FAIL nowarm_load vec=%b count=%0d exp vec=01010 count=0", b_vec, b_count);
    end
    cyc();
    total++;
    if (b_vec !== 5'b10110) begin
      bad++;
      $display("[TB] FAIL nowarm_run vec=%b exp=10110", b_vec);
    end
    cyc();
    total++;
    if (b_vec !== 5'b00001 || b_count !== 4'd1) begin
      bad++;
      $display("[TB] FAIL nowarm_done vec=%b count=%0d exp vec=00001 count=1", b_vec, b_count);
    end
    cyc();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    a_start = 1'b0; a_stop = 1'b0; a_mode = 1'b0; a_seed = 1'b0; a_ready = 1'b0; a_len = 16'd0;
    b_start = 1'b0; b_stop = 1'b0; b_mode = 1'b0; b_seed = 1'b0; b_ready = 1'b0; b_len = 4'd0;
    $display("[TB] starting random_engine_seq_ctrl bench");
    test_reset();
    test_seeded_burst();
    test_backpressure();
    test_stop_priority();
    test_corner_starts();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
